// File: rtl/adc_avg_window_if.sv
// Average output stream between adc_avg_window and its consumer (bus wrapper / FIFO).
interface adc_avg_window_if #(
    parameter int DW = 12
);
    logic          avg_valid;
    logic          avg_ready;
    logic [DW-1:0] avg_data;
    logic [2:0]    avg_ch;

    modport master (output avg_valid, avg_data, avg_ch, input avg_ready);
    modport slave  (input avg_valid, avg_data, avg_ch, output avg_ready);
endinterface

// File: rtl/adc_avg_window.sv
// SAR post-processing: per-channel power-of-two averaging, valid/ready output register,
// sticky out-of-window and overrun flags with W1C clear.
module adc_avg_window #(
    parameter int DW    = 12,
    parameter int ACC_W = 19
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 eoc,
    input  logic                 sample_n,
    input  logic [DW-1:0]        adc_data,
    input  logic [2:0]           ch_sel,
    input  logic [2:0]           avg_log2,
    input  logic [DW-1:0]        lo_th,
    input  logic [DW-1:0]        hi_th,
    adc_avg_window_if.master     avg_if,
    output logic [7:0]           win_flag,
    output logic                 overrun,
    input  logic [8:0]           flag_clr,
    output logic                 irq
);
    logic             eoc_q, sample_n_q;
    logic [2:0]       tag, avg_log2_q;
    logic [ACC_W-1:0] acc [8];
    logic [6:0]       cnt [8];

    logic             log_chg, evt, full, res_vld, res_out, load, drop;
    logic [ACC_W-1:0] sum, sum_sh;
    logic [DW-1:0]    result;
    logic [6:0]       cnt_last;

    always_comb begin
        log_chg  = avg_log2 != avg_log2_q;
        evt      = en & eoc & ~eoc_q & ~log_chg;
        sum      = acc[tag] + ACC_W'(adc_data);
        sum_sh   = sum >> avg_log2;
        result   = sum_sh[DW-1:0];
        cnt_last = 7'((8'd1 << avg_log2) - 8'd1);
        full     = cnt[tag] == cnt_last;
        res_vld  = evt & full;
        res_out  = (result < lo_th) | (result > hi_th);
        load     = res_vld & (~avg_if.avg_valid | avg_if.avg_ready);
        drop     = res_vld & avg_if.avg_valid & ~avg_if.avg_ready;
    end

    // eoc_q comes out of reset high so a conversion already in progress at
    // reset release is not mistaken for a rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eoc_q      <= 1'b1;
            sample_n_q <= 1'b0;
            tag        <= '0;
            avg_log2_q <= '0;
        end else begin
            eoc_q      <= eoc;
            sample_n_q <= sample_n;
            avg_log2_q <= avg_log2;
            if (sample_n_q && !sample_n) tag <= ch_sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 8; c++) begin
                acc[c] <= '0;
                cnt[c] <= '0;
            end
        end else begin
            for (int c = 0; c < 8; c++) begin
                if (!en || log_chg) begin
                    acc[c] <= '0;
                    cnt[c] <= '0;
                end else if (evt && tag == 3'(c)) begin
                    if (full) begin
                        acc[c] <= '0;
                        cnt[c] <= '0;
                    end else begin
                        acc[c] <= sum;
                        cnt[c] <= cnt[c] + 7'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            avg_if.avg_valid <= 1'b0;
            avg_if.avg_data  <= '0;
            avg_if.avg_ch    <= '0;
        end else if (!en) begin
            avg_if.avg_valid <= 1'b0;
        end else if (load) begin
            avg_if.avg_valid <= 1'b1;
            avg_if.avg_data  <= result;
            avg_if.avg_ch    <= tag;
        end else if (avg_if.avg_ready) begin
            avg_if.avg_valid <= 1'b0;
        end
    end

    // Dropped results still get the window check; a set wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_flag <= '0;
            overrun  <= 1'b0;
        end else begin
            win_flag <= (win_flag & ~flag_clr[7:0]) | ((res_vld && res_out) ? (8'd1 << tag) : 8'd0);
            overrun  <= (overrun & ~flag_clr[8]) | drop;
        end
    end

    assign irq = (|win_flag) | overrun;
endmodule

// File: tb/tb_adc_avg_window.sv
// Directed bench for adc_avg_window: sample-list averaging model checked every cycle,
// plus literal expectations per scenario.
module tb_adc_avg_window;
    localparam int DW    = 12;
    localparam int ACC_W = 19;

    logic          clk = 1'b0, rst_n = 1'b0, en = 1'b0, eoc = 1'b0, sample_n = 1'b1;
    logic [DW-1:0] adc_data = '0, lo_th = '0, hi_th = 12'hFFF;
    logic [2:0]    ch_sel = '0, avg_log2 = '0;
    logic [8:0]    flag_clr = '0;
    logic          ready = 1'b1;
    logic [7:0]    win_flag;
    logic          overrun, irq;

    adc_avg_window_if #(.DW(DW)) avg_if ();
    assign avg_if.avg_ready = ready;

    adc_avg_window #(.DW(DW), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .eoc(eoc), .sample_n(sample_n),
        .adc_data(adc_data), .ch_sel(ch_sel), .avg_log2(avg_log2),
        .lo_th(lo_th), .hi_th(hi_th), .avg_if(avg_if),
        .win_flag(win_flag), .overrun(overrun), .flag_clr(flag_clr), .irq(irq)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: per channel, the samples since the last flush; the average is their
    // arithmetic mean once 2^avg_log2 have arrived.
    bit       m_eoc_q, m_sn_q, m_valid, m_ovr;
    int       m_tag, m_log_q, m_data, m_ch;
    int       m_sum [8];
    int       m_n   [8];
    bit [7:0] m_win;

    task automatic model_flush();
        for (int c = 0; c < 8; c++) begin
            m_sum[c] = 0;
            m_n[c]   = 0;
        end
    endtask

    task automatic model_reset();
        model_flush();
        m_eoc_q = 1'b1; m_sn_q = 1'b0; m_valid = 1'b0; m_ovr = 1'b0;
        m_tag = 0; m_log_q = 0; m_data = 0; m_ch = 0; m_win = '0;
    endtask

    task automatic model_step();
        bit rise, fall, has;
        int res, n_need;
        rise   = eoc && !m_eoc_q;
        fall   = m_sn_q && !sample_n;
        has    = 1'b0;
        res    = 0;
        n_need = 1 << avg_log2;
        if (!en || int'(avg_log2) != m_log_q) begin
            model_flush();
        end else if (rise) begin
            m_sum[m_tag] += int'(adc_data);
            m_n[m_tag]++;
            if (m_n[m_tag] == n_need) begin
                res = m_sum[m_tag] / n_need;
                has = 1'b1;
                m_sum[m_tag] = 0;
                m_n[m_tag]   = 0;
            end
        end
        m_win = m_win & ~flag_clr[7:0];
        if (flag_clr[8]) m_ovr = 1'b0;
        if (!en) begin
            m_valid = 1'b0;
        end else if (has) begin
            if (m_valid && !ready) m_ovr = 1'b1;
            else begin
                m_valid = 1'b1;
                m_data  = res;
                m_ch    = m_tag;
            end
            if (res < int'(lo_th) || res > int'(hi_th)) m_win[m_tag] = 1'b1;
        end else if (m_valid && ready) begin
            m_valid = 1'b0;
        end
        if (fall) m_tag = int'(ch_sel);
        m_eoc_q = eoc;
        m_sn_q  = sample_n;
        m_log_q = int'(avg_log2);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("cyc_valid", avg_if.avg_valid, m_valid);
                if (m_valid) begin
                    chk("cyc_data", avg_if.avg_data, m_data);
                    chk("cyc_ch", avg_if.avg_ch, m_ch);
                end
                chk("cyc_win", win_flag, m_win);
                chk("cyc_ovr", overrun, m_ovr);
                chk("cyc_irq", irq, (m_win != 0) || m_ovr);
            end
        end
    end

    // Output state seen on the cycle right after the conversion's eoc rise.
    logic          lv;
    logic [DW-1:0] ld;
    logic [2:0]    lc;

    task automatic conv(input int ch, input int d, input logic [8:0] clr = 9'h0);
        ch_sel = 3'(ch); sample_n = 1'b0;
        @(negedge clk);
        sample_n = 1'b1; adc_data = DW'(d); eoc = 1'b1; flag_clr = clr;
        @(negedge clk);
        lv = avg_if.avg_valid; ld = avg_if.avg_data; lc = avg_if.avg_ch;
        eoc = 1'b0; flag_clr = '0;
        @(negedge clk);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // 1: reset with eoc held high
        eoc = 1'b1; avg_log2 = 3'd2; en = 1'b1;
        cyc(3);
        chk("rst_valid", avg_if.avg_valid, 0);
        chk("rst_data", avg_if.avg_data, 0);
        chk("rst_ch", avg_if.avg_ch, 0);
        chk("rst_win", win_flag, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_irq", irq, 0);
        rst_n = 1'b1;
        cyc(3);
        chk("rst_exit_valid", avg_if.avg_valid, 0);
        eoc = 1'b0;
        cyc(2);

        // 2: four samples on ch3
        conv(3, 100); chk("t2_s1", lv, 0);
        conv(3, 101); chk("t2_s2", lv, 0);
        conv(3, 102); chk("t2_s3", lv, 0);
        conv(3, 105);
        chk("t2_valid", lv, 1); chk("t2_data", ld, 102); chk("t2_ch", lc, 3);

        // 3: interleaved channels
        avg_log2 = 3'd1; cyc(2);
        conv(0, 10);
        conv(1, 1000); chk("t3_mid", lv, 0);
        conv(0, 20);
        chk("t3_ch0_v", lv, 1); chk("t3_ch0_d", ld, 15); chk("t3_ch0_c", lc, 0);
        conv(1, 1002);
        chk("t3_ch1_v", lv, 1); chk("t3_ch1_d", ld, 1001); chk("t3_ch1_c", lc, 1);

        // 4: backpressure and overrun
        avg_log2 = 3'd0; cyc(2);
        ready = 1'b0;
        conv(2, 300); chk("t4_first", ld, 300);
        conv(2, 400);
        chk("t4_hold_v", lv, 1); chk("t4_hold_d", ld, 300);
        chk("t4_ovr", overrun, 1); chk("t4_irq", irq, 1);
        ready = 1'b1; cyc(1);
        chk("t4_drain", avg_if.avg_valid, 0);
        flag_clr = 9'h100; cyc(1); flag_clr = '0;
        chk("t4_ovr_clr", overrun, 0); chk("t4_irq_clr", irq, 0);

        // 5: window flags
        lo_th = 12'd200; hi_th = 12'd800;
        conv(5, 900); chk("t5_win", win_flag, 8'h20); chk("t5_irq", irq, 1);
        conv(5, 500); chk("t5_keep", win_flag, 8'h20);
        conv(5, 950, 9'h020); chk("t5_set_wins", win_flag, 8'h20);
        flag_clr = 9'h020; cyc(1); flag_clr = '0;
        chk("t5_clr", win_flag, 0); chk("t5_irq_clr", irq, 0);
        lo_th = 12'd900; hi_th = 12'd100;
        conv(1, 500); chk("t5_inverted", win_flag, 8'h02);
        flag_clr = 9'h0FF; cyc(1); flag_clr = '0;
        lo_th = '0; hi_th = 12'hFFF;

        // 6: partial sums discarded by avg_log2 change and by en low
        avg_log2 = 3'd3; cyc(2);
        conv(4, 7); conv(4, 7); conv(4, 7);
        avg_log2 = 3'd1; cyc(2);
        conv(4, 40); chk("t6a_mid", lv, 0);
        conv(4, 60); chk("t6a_v", lv, 1); chk("t6a_d", ld, 50); chk("t6a_c", lc, 4);
        conv(4, 40);
        en = 1'b0; cyc(1); en = 1'b1; cyc(1);
        conv(4, 40); chk("t6b_mid", lv, 0);
        conv(4, 60); chk("t6b_v", lv, 1); chk("t6b_d", ld, 50);

        // 7: 128 full-scale samples, no accumulator overflow
        avg_log2 = 3'd7; cyc(2);
        for (int i = 0; i < 127; i++) conv(6, 4095);
        chk("t7_mid", lv, 0);
        conv(6, 4095);
        chk("t7_v", lv, 1); chk("t7_d", ld, 4095); chk("t7_c", lc, 6);

        cyc(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
